// File: rtl/stream_demux.sv
// Packet-locked 1-to-N stream router with a one-beat register per output; unknown ids are sunk.
// Define STREAM_DEMUX_DROP_CNT_EN to add the saturating dropped-packet counter on drop_cnt_o.
module stream_demux #(
   parameter int T_DATA_WIDTH = 8,
   parameter int T_QOS__WIDTH = 4,
   parameter int STREAM_COUNT = 4,
   parameter int T_ID___WIDTH = 3
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [T_DATA_WIDTH-1:0]                   s_data_i,
   input  logic [T_QOS__WIDTH-1:0]                   s_qos_i,
   input  logic [T_ID___WIDTH-1:0]                   s_id_i,
   input  logic                                      s_last_i,
   input  logic                                      s_valid_i,
   output logic                                      s_ready_o,
   output logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_o,
   output logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] m_qos_o,
   output logic [STREAM_COUNT-1:0]                   m_last_o,
   output logic [STREAM_COUNT-1:0]                   m_valid_o,
   input  logic [STREAM_COUNT-1:0]                   m_ready_i
`ifdef STREAM_DEMUX_DROP_CNT_EN
   ,
   output logic [15:0]                               drop_cnt_o
`endif
);

   // state | meaning
   // IDLE  | between packets; the next beat picks its output from s_id_i
   // FWD   | inside a packet to a valid output; destination held in lock_id
   // DROP  | inside a packet with an unknown id; beats accepted and discarded
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t                  state, state_nxt;
   logic [T_ID___WIDTH-1:0] lock_id, lock_id_nxt;
   logic [T_ID___WIDTH-1:0] sel;
   logic                    id_valid;
   logic                    sel_free;
   logic                    accept;
   logic                    fwd_beat;
   logic                    drop_last;
   logic [STREAM_COUNT-1:0] load;

   assign id_valid = int'(s_id_i) < STREAM_COUNT;
   assign sel      = (state == FWD) ? lock_id : s_id_i;

   // Selected output can take a beat if empty or draining this cycle.
   always_comb begin
      sel_free = 1'b0;
      for (int k = 0; k < STREAM_COUNT; k++) begin
         if (int'(sel) == k) begin
            sel_free = !m_valid_o[k] || m_ready_i[k];
         end
      end
   end

   always_comb begin
      s_ready_o = 1'b0;
      if (rst_n) begin
         case (state)
            DROP:    s_ready_o = 1'b1;
            FWD:     s_ready_o = sel_free;
            default: s_ready_o = id_valid ? sel_free : 1'b1;
         endcase
      end
   end

   assign accept    = s_valid_i && s_ready_o;
   assign fwd_beat  = accept && ((state == FWD) || ((state == IDLE) && id_valid));
   assign drop_last = accept && s_last_i &&
                      ((state == DROP) || ((state == IDLE) && !id_valid));

   always_comb begin
      load = '0;
      for (int k = 0; k < STREAM_COUNT; k++) begin
         load[k] = fwd_beat && (int'(sel) == k);
      end
   end

   always_comb begin
      state_nxt   = state;
      lock_id_nxt = lock_id;
      case (state)
         IDLE: begin
            if (accept && !s_last_i) begin
               lock_id_nxt = s_id_i;
               state_nxt   = id_valid ? FWD : DROP;
            end
         end
         FWD, DROP: begin
            if (accept && s_last_i) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         lock_id <= '0;
      end else begin
         state   <= state_nxt;
         lock_id <= lock_id_nxt;
      end
   end

   // Load wins over drain, so a full output sustains one beat per cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_valid_o <= '0;
         m_data_o  <= '0;
         m_qos_o   <= '0;
         m_last_o  <= '0;
      end else begin
         for (int k = 0; k < STREAM_COUNT; k++) begin
            if (load[k]) begin
               m_valid_o[k] <= 1'b1;
               m_data_o[k]  <= s_data_i;
               m_qos_o[k]   <= s_qos_i;
               m_last_o[k]  <= s_last_i;
            end else if (m_ready_i[k]) begin
               m_valid_o[k] <= 1'b0;
            end
         end
      end
   end

`ifdef STREAM_DEMUX_DROP_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_cnt_o <= '0;
      end else if (drop_last && (drop_cnt_o != 16'hFFFF)) begin
         drop_cnt_o <= drop_cnt_o + 16'd1;
      end
   end
`else
   logic unused_drop;
   assign unused_drop = drop_last;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Randomized scoreboard bench for stream_demux: a packet-level model predicts routing, readiness and
// per-output beat order; a separate monitor compares each presented output beat against its queue.
module tb_stream_demux;
   localparam int DW = 8;
   localparam int QW = 4;
   localparam int N  = 4;
   localparam int IW = 3;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [DW-1:0]          s_data_i = '0;
   logic [QW-1:0]          s_qos_i = '0;
   logic [IW-1:0]          s_id_i = '0;
   logic                   s_last_i = 1'b0;
   logic                   s_valid_i = 1'b0;
   logic                   s_ready_o;
   logic [N-1:0][DW-1:0]   m_data_o;
   logic [N-1:0][QW-1:0]   m_qos_o;
   logic [N-1:0]           m_last_o;
   logic [N-1:0]           m_valid_o;
   logic [N-1:0]           m_ready_i = '1;
`ifdef STREAM_DEMUX_DROP_CNT_EN
   logic [15:0]            drop_cnt_o;
`endif

   stream_demux #(
      .T_DATA_WIDTH(DW),
      .T_QOS__WIDTH(QW),
      .STREAM_COUNT(N),
      .T_ID___WIDTH(IW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .s_data_i(s_data_i),
      .s_qos_i(s_qos_i),
      .s_id_i(s_id_i),
      .s_last_i(s_last_i),
      .s_valid_i(s_valid_i),
      .s_ready_o(s_ready_o),
      .m_data_o(m_data_o),
      .m_qos_o(m_qos_o),
      .m_last_o(m_last_o),
      .m_valid_o(m_valid_o),
      .m_ready_i(m_ready_i)
`ifdef STREAM_DEMUX_DROP_CNT_EN
      ,
      .drop_cnt_o(drop_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [QW-1:0] q;
      logic          l;
   } beat_t;

   int      n_vec = 0;
   int      n_fail = 0;
   int      ready_pct = 100;
   beat_t   exp_q[N][$];
   logic [N-1:0] occ = '0;
   logic [N-1:0] ld;
   bit      in_pkt = 1'b0;
   int      pkt_dest = 0;
   int      dest;
   bit      exp_rdy;
   int      drop_exp = 0;
   beat_t   head;

   task automatic chk(input string name, input longint act, input longint req);
      n_vec++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < N; k++) m_ready_i[k] = ($urandom_range(99) < ready_pct);
      end
   end

   // Reference model: packet destination comes from the first beat; each output holds one beat.
   always @(negedge clk) begin
      chk("m_valid_vs_model", m_valid_o, occ);
`ifdef STREAM_DEMUX_DROP_CNT_EN
      chk("drop_cnt", drop_cnt_o, drop_exp);
`endif
      if (!rst_n) begin
         chk("s_ready_in_reset", s_ready_o, 0);
         occ = '0;
         in_pkt = 1'b0;
         drop_exp = 0;
         for (int k = 0; k < N; k++) exp_q[k].delete();
      end else begin
         dest = in_pkt ? pkt_dest : int'(s_id_i);
         if (dest >= N) exp_rdy = 1'b1;
         else           exp_rdy = !occ[dest] || m_ready_i[dest];
         chk("s_ready", s_ready_o, exp_rdy);
         ld = '0;
         if (s_valid_i && s_ready_o) begin
            if (dest < N) begin
               exp_q[dest].push_back({s_data_i, s_qos_i, s_last_i});
               ld[dest] = 1'b1;
            end else if (s_last_i && drop_exp < 65535) begin
               drop_exp++;
            end
            if (s_last_i) in_pkt = 1'b0;
            else if (!in_pkt) begin
               in_pkt = 1'b1;
               pkt_dest = dest;
            end
         end
         for (int k = 0; k < N; k++) begin
            if (ld[k])             occ[k] = 1'b1;
            else if (m_ready_i[k]) occ[k] = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < N; k++) begin
            if (m_valid_o[k]) begin
               if (exp_q[k].size() == 0) begin
                  chk("spurious_m_valid", m_valid_o[k], 0);
               end else begin
                  head = exp_q[k][0];
                  chk("m_data", m_data_o[k], head.d);
                  chk("m_qos", m_qos_o[k], head.q);
                  chk("m_last", m_last_o[k], head.l);
                  if (m_ready_i[k]) void'(exp_q[k].pop_front());
               end
            end
         end
      end
   end

   task automatic send_beat(input logic [DW-1:0] d, input logic [QW-1:0] q,
                            input logic [IW-1:0] id, input logic last);
      int n = 0;
      s_valid_i = 1'b1;
      s_data_i  = d;
      s_qos_i   = q;
      s_id_i    = id;
      s_last_i  = last;
      @(negedge clk);
      while (!s_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("accept_timeout", n, 0);
      @(posedge clk);
      #1;
      s_valid_i = 1'b0;
   endtask

   task automatic send_packet(input logic [IW-1:0] id, input int len);
      for (int i = 0; i < len; i++) begin
         if ($urandom_range(3) == 0) begin
            s_id_i = IW'($urandom_range(7));
            @(posedge clk);
            #1;
         end
         send_beat(DW'($urandom), QW'($urandom), (i == 0) ? id : IW'($urandom_range(7)),
                   i == len - 1);
      end
   endtask

   task automatic idle(input int n);
      s_valid_i = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      s_valid_i = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      s_valid_i = 1'b0;
      idle(2);

      send_beat(8'hA1, 4'd5, 3'd2, 1'b0);
      send_beat(8'hA2, 4'd5, 3'd2, 1'b0);
      send_beat(8'hA3, 4'd5, 3'd2, 1'b1);
      idle(2);

      send_beat(8'h31, 4'd1, 3'd1, 1'b0);
      send_beat(8'h32, 4'd2, 3'd3, 1'b0);
      send_beat(8'h33, 4'd3, 3'd0, 1'b1);
      idle(2);

      for (int i = 0; i < 4; i++) send_beat(8'hD0 + 8'(i), 4'hF, 3'd6, i == 3);
      send_beat(8'h55, 4'd7, 3'd0, 1'b1);
      idle(3);

      for (int i = 0; i < 4; i++) begin
         s_valid_i = 1'b1;
         s_id_i    = IW'(i);
         s_last_i  = 1'b1;
         s_data_i  = 8'h60 + 8'(i);
         s_qos_i   = QW'(i);
         @(negedge clk);
         chk("b2b_s_ready", s_ready_o, 1);
         if (i > 0) chk("b2b_walk", m_valid_o, 4'b0001 << (i - 1));
         @(posedge clk);
         #1;
      end
      s_valid_i = 1'b0;
      @(negedge clk);
      chk("b2b_walk", m_valid_o, 4'b1000);
      idle(2);

      ready_pct = 70;
      for (int p = 0; p < 300; p++) send_packet(IW'($urandom_range(7)), $urandom_range(1, 4));
      ready_pct = 30;
      for (int p = 0; p < 100; p++) send_packet(IW'($urandom_range(7)), $urandom_range(1, 4));

      ready_pct = 50;
      send_beat(8'h71, 4'd1, 3'd1, 1'b0);
      send_beat(8'h72, 4'd1, 3'd1, 1'b0);
      rst_n = 1'b0;
      s_valid_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      s_valid_i = 1'b0;
      for (int p = 0; p < 50; p++) send_packet(IW'($urandom_range(7)), $urandom_range(1, 4));

      ready_pct = 100;
      idle(10);
      for (int k = 0; k < N; k++) chk("leftover_beats", exp_q[k].size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
